// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Optional feature macro: IF_STAGE_PERF_EN (fetch/stall performance counters).
package if_stage_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    STALL = 1'b1
  } if_state_t;

  localparam int          WORD_WIDTH_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0;
  localparam int          PC_STEP_DEFAULT    = 4;

endpackage

// File: rtl/if_stage_pc_reg.sv
// PC register: async active-low reset, branch load, sequential increment.
// Load wins over increment; arithmetic wraps modulo 2^WORD_WIDTH.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter int                    WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = WORD_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_addr,
  input  logic                  inc,
  output logic [WORD_WIDTH-1:0] value
);

  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(PC_STEP);

  // Redirect target first, otherwise step past the word just consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= RESET_PC;
    end else if (load) begin
      value <= load_addr;
    end else if (inc) begin
      value <= value + STEP;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch handshake to
// instruction memory and hands {pc, instruction, valid} to decode.
// pc presented to decode is fetch address + PC_STEP.
// Optional feature macro: IF_STAGE_PERF_EN adds fetch_count / stall_count.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                    WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = WORD_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  instruction_valid
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);

  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(PC_STEP);

  if_state_t             state;
  logic                  kill;       // outstanding request belongs to a squashed path
  logic [WORD_WIDTH-1:0] kill_addr;  // address of that squashed request, kept on the bus
  logic [WORD_WIDTH-1:0] hold_reg;   // word parked while decode is frozen
  logic [WORD_WIDTH-1:0] pc_q;
  logic [WORD_WIDTH-1:0] pc_next;

  logic fetch_deliver;
  logic stall_deliver;
  logic deliver;
  logic req_open;

  // A request is open whenever we sit in FETCH; memory sees it until ack.
  assign req_open      = (state == FETCH);
  assign imem_req      = req_open;
  assign imem_addr     = kill ? kill_addr : pc_q;

  assign fetch_deliver = req_open && imem_ack && !kill && !freeze && !branch_taken;
  assign stall_deliver = (state == STALL) && !freeze && !branch_taken;
  assign deliver       = fetch_deliver || stall_deliver;
  assign pc_next       = pc_q + STEP;

  if_stage_pc_reg #(
    .WORD_WIDTH (WORD_WIDTH),
    .RESET_PC   (RESET_PC),
    .PC_STEP    (PC_STEP)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (branch_taken),
    .load_addr (branch_addr),
    .inc       (deliver),
    .value     (pc_q)
  );

  // Fetch FSM with kill tracking and registered decode outputs.
  // Priority: branch redirect, then memory ack, then freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= FETCH;
      kill              <= 1'b0;
      kill_addr         <= RESET_PC;
      hold_reg          <= '0;
      pc                <= '0;
      instruction       <= '0;
      instruction_valid <= 1'b0;
    end else if (branch_taken) begin
      // Redirect: any word in flight or parked is discarded; freeze ignored.
      state             <= FETCH;
      instruction_valid <= 1'b0;
      hold_reg          <= '0;
      // Request still open with no ack: its ack must be swallowed later, and
      // the bus keeps the old address until then.
      kill <= req_open && !imem_ack;
      if (req_open && !imem_ack && !kill) kill_addr <= pc_q;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (kill) begin
              kill              <= 1'b0;
              instruction_valid <= 1'b0;
            end else if (!freeze) begin
              instruction       <= imem_rdata;
              pc                <= pc_next;
              instruction_valid <= 1'b1;
            end else begin
              hold_reg <= imem_rdata;
              state    <= STALL;
            end
          end else if (!freeze) begin
            instruction_valid <= 1'b0;
          end
        end
        STALL: begin
          if (!freeze) begin
            instruction       <= hold_reg;
            pc                <= pc_next;
            instruction_valid <= 1'b1;
            state             <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IF_STAGE_PERF_EN
  // Performance counters: delivered instructions and frozen cycles, free-wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (deliver) fetch_count <= fetch_count + 32'd1;
      if (freeze)  stall_count <= stall_count + 32'd1;
    end
  end
`endif

  // A squashed request can only exist while a request is open.
  a_kill_in_fetch : assert property (@(posedge clk) disable iff (!rst) kill |-> req_open);

endmodule
